// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO for the UART transmit path.
// The writer is the CPU-side register interface and the reader is the transmit shift engine.
// Occupancy and status flags are registered, so none of them depend combinationally on winc/rinc.
// Overflow and underflow are sticky until err_clr.
// FWFT=1 shows the head entry combinationally; FWFT=0 loads a data register on each accepted read.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b1
) (
  input  logic                  i_riscv_fifo_clk,
  input  logic                  i_riscv_fifo_rst_n,
  input  logic                  i_riscv_fifo_flush,
  input  logic                  i_riscv_fifo_err_clr,
  input  logic                  i_riscv_fifo_winc,
  input  logic [DATA_WIDTH-1:0] i_riscv_fifo_wdata,
  input  logic                  i_riscv_fifo_rinc,
  output logic [DATA_WIDTH-1:0] o_riscv_fifo_rdata,
  output logic                  o_riscv_fifo_full,
  output logic                  o_riscv_fifo_empty,
  output logic                  o_riscv_fifo_almost_full,
  output logic                  o_riscv_fifo_almost_empty,
  output logic [PTR_WIDTH-1:0]  o_riscv_fifo_count,
  output logic                  o_riscv_fifo_overflow,
  output logic                  o_riscv_fifo_underflow
);

  localparam int AW = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] DEPTH_C = PTR_WIDTH'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] AF_C    = PTR_WIDTH'(AF_THRESH);
  localparam logic [PTR_WIDTH-1:0] AE_C    = PTR_WIDTH'(AE_THRESH);
  localparam logic [PTR_WIDTH-1:0] ONE_C   = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] ZERO_C  = PTR_WIDTH'(0);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic [PTR_WIDTH-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 afull_q, afull_d;
  logic                 aempty_q, aempty_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 rd_ok_s, wr_ok_s, mem_we_s, rd_ld_s;
  logic                 ovf_evt_s, unf_evt_s;
  logic [AW-1:0]        waddr_s, raddr_s;

  // Request acceptance and error events, all decided from registered status only
  always_comb begin
    rd_ok_s   = i_riscv_fifo_rinc & ~empty_q;
    wr_ok_s   = i_riscv_fifo_winc & (~full_q | rd_ok_s);
    ovf_evt_s = i_riscv_fifo_winc & ~wr_ok_s & ~i_riscv_fifo_flush;
    unf_evt_s = i_riscv_fifo_rinc & ~rd_ok_s & ~i_riscv_fifo_flush;
    mem_we_s  = wr_ok_s & ~i_riscv_fifo_flush & i_riscv_fifo_rst_n;
    rd_ld_s   = rd_ok_s & ~i_riscv_fifo_flush;
    waddr_s   = wptr_q[AW-1:0];
    raddr_s   = rptr_q[AW-1:0];
  end

  // Next pointers, occupancy and decoded status; flush overrides any request this cycle
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (i_riscv_fifo_flush) begin
      wptr_d = ZERO_C;
      rptr_d = ZERO_C;
    end else begin
      if (wr_ok_s) begin
        wptr_d = wptr_q + ONE_C;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_ok_s) begin
        rptr_d = rptr_q + ONE_C;
      end else begin
        rptr_d = rptr_q;
      end
    end
    // Pointers wrap modulo 2*depth, so the difference is the occupancy 0..depth
    count_d  = wptr_d - rptr_d;
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == ZERO_C);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  // Sticky error flags: a new error event in the same cycle beats err_clr
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (i_riscv_fifo_err_clr) begin
      ovf_d = ovf_evt_s;
      unf_d = unf_evt_s;
    end else begin
      ovf_d = ovf_q | ovf_evt_s;
      unf_d = unf_q | unf_evt_s;
    end
  end

  // Control and status registers with synchronous active-low reset
  always_ff @(posedge i_riscv_fifo_clk) begin
    if (!i_riscv_fifo_rst_n) begin
      wptr_q   <= ZERO_C;
      rptr_q   <= ZERO_C;
      count_q  <= ZERO_C;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; deliberately not reset
  always_ff @(posedge i_riscv_fifo_clk) begin
    if (mem_we_s) begin
      mem_q[waddr_s] <= i_riscv_fifo_wdata;
    end
  end

  generate
    if (FWFT) begin : g_show_ahead
      // Head entry is presented directly; it is only meaningful while not empty
      assign o_riscv_fifo_rdata = mem_q[raddr_s];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rdata_q;

      // Read data register: loads on an accepted read and holds otherwise
      always_ff @(posedge i_riscv_fifo_clk) begin
        if (!i_riscv_fifo_rst_n) begin
          rdata_q <= {DATA_WIDTH{1'b0}};
        end else if (rd_ld_s) begin
          rdata_q <= mem_q[raddr_s];
        end else begin
          rdata_q <= rdata_q;
        end
      end

      assign o_riscv_fifo_rdata = rdata_q;
    end
  endgenerate

  assign o_riscv_fifo_full         = full_q;
  assign o_riscv_fifo_empty        = empty_q;
  assign o_riscv_fifo_almost_full  = afull_q;
  assign o_riscv_fifo_almost_empty = aempty_q;
  assign o_riscv_fifo_count        = count_q;
  assign o_riscv_fifo_overflow     = ovf_q;
  assign o_riscv_fifo_underflow    = unf_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Scoreboard bench for uart_sync_fifo.
// dut is the show-ahead instance and dut0 is the registered-read instance.
module tb_uart_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       err_clr = 1'b0;
  logic       winc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rinc = 1'b0;
  logic       winc0 = 1'b0;
  logic [7:0] wdata0 = 8'h00;
  logic       rinc0 = 1'b0;

  logic [7:0] rdata, rdata0;
  logic       full, empty, afull, aempty, ovf, unf;
  logic       full0, empty0, afull0, aempty0, ovf0, unf0;
  logic [4:0] count, count0;

  int n_cmp = 0;
  int n_bad = 0;
  int mcount = 0;
  logic [7:0] mq[$];
  logic [7:0] mq0[$];
  logic [7:0] exp0 = 8'h00;
  bit pend0 = 1'b0;

  always #5 clk = ~clk;

  uart_sync_fifo dut (
    .i_riscv_fifo_clk(clk), .i_riscv_fifo_rst_n(rst_n), .i_riscv_fifo_flush(flush),
    .i_riscv_fifo_err_clr(err_clr), .i_riscv_fifo_winc(winc), .i_riscv_fifo_wdata(wdata),
    .i_riscv_fifo_rinc(rinc), .o_riscv_fifo_rdata(rdata), .o_riscv_fifo_full(full),
    .o_riscv_fifo_empty(empty), .o_riscv_fifo_almost_full(afull),
    .o_riscv_fifo_almost_empty(aempty), .o_riscv_fifo_count(count),
    .o_riscv_fifo_overflow(ovf), .o_riscv_fifo_underflow(unf)
  );

  uart_sync_fifo #(.FWFT(1'b0)) dut0 (
    .i_riscv_fifo_clk(clk), .i_riscv_fifo_rst_n(rst_n), .i_riscv_fifo_flush(flush),
    .i_riscv_fifo_err_clr(err_clr), .i_riscv_fifo_winc(winc0), .i_riscv_fifo_wdata(wdata0),
    .i_riscv_fifo_rinc(rinc0), .o_riscv_fifo_rdata(rdata0), .o_riscv_fifo_full(full0),
    .o_riscv_fifo_empty(empty0), .o_riscv_fifo_almost_full(afull0),
    .o_riscv_fifo_almost_empty(aempty0), .o_riscv_fifo_count(count0),
    .o_riscv_fifo_overflow(ovf0), .o_riscv_fifo_underflow(unf0)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle on the show-ahead instance; the reference queue tracks accepted writes
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit fl, input bit ec);
    bit rd_ok;
    bit wr_ok;
    winc = w; wdata = d; rinc = r; flush = fl; err_clr = ec;
    rd_ok = r && (mcount != 0);
    wr_ok = w && ((mcount != 16) || rd_ok);
    if (fl) begin
      mq.delete();
      mcount = 0;
    end else begin
      if (wr_ok) mq.push_back(d);
      mcount = mcount + int'(wr_ok) - int'(rd_ok);
    end
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  // One cycle on the registered-read instance (only used on a non-full FIFO)
  task automatic step0(input bit w, input logic [7:0] d, input bit r);
    winc0 = w; wdata0 = d; rinc0 = r;
    if (w) mq0.push_back(d);
    @(posedge clk); #1;
    winc0 = 1'b0; rinc0 = 1'b0;
  endtask

  // Show-ahead monitor: a read is about to be accepted, so the displayed word must be the queue head
  always @(negedge clk) begin
    if (rst_n && !flush && rinc && !empty) begin
      if (mq.size() == 0) begin
        chk("sb_underrun", 1, 0);
      end else begin
        chk("rdata_fwft", int'(rdata), int'(mq.pop_front()));
      end
    end
  end

  // Registered-read monitor: the word read at the previous edge must now be on rdata
  always @(negedge clk) begin
    if (pend0) begin
      chk("rdata_reg", int'(rdata0), int'(exp0));
      pend0 = 1'b0;
    end
    if (rst_n && !flush && rinc0 && !empty0) begin
      if (mq0.size() == 0) begin
        chk("sb0_underrun", 1, 0);
      end else begin
        exp0 = mq0.pop_front();
        pend0 = 1'b1;
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_aempty"}, int'(aempty), 1);
    chk({tag, "_afull"}, int'(afull), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_unf"}, int'(unf), 0);
    chk({tag, "_count0"}, int'(count0), 0);
    chk({tag, "_empty0"}, int'(empty0), 1);
    chk({tag, "_rdata0"}, int'(rdata0), 0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rst_n = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("fill_count", int'(count), i + 1);
      chk("fill_afull", int'(afull), (i + 1 >= 14) ? 1 : 0);
      chk("fill_aempty", int'(aempty), (i + 1 <= 2) ? 1 : 0);
    end
    chk("full_at16", int'(full), 1);
    chk("empty_at16", int'(empty), 0);

    // 17th write is dropped
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_count", int'(count), 16);
    chk("head_before_read", int'(rdata), 8'h00);

    // Clear errors, then write+read at full
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("errclr_ovf", int'(ovf), 0);
    step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    chk("full_wr_rd_count", int'(count), 16);
    chk("full_wr_rd_ovf", int'(ovf), 0);

    // Drain 0x01..0x10 and check that the FIFO is empty at the end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_count", int'(count), 0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_unf_clear", int'(unf), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("unf_set", int'(unf), 1);
    chk("unf_empty", int'(empty), 1);
    chk("unf_count", int'(count), 0);

    // An error event in the same cycle as err_clr keeps the flag set
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("errclr_vs_event", int'(unf), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("errclr_unf", int'(unf), 0);

    // Write+read at empty: write taken, read rejected
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("empty_wr_rd_count", int'(count), 1);
    chk("empty_wr_rd_unf", int'(unf), 1);
    chk("empty_wr_rd_head", int'(rdata), 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("after_3c_empty", int'(empty), 1);

    // Wrap-around at constant occupancy of 8
    for (int i = 0; i < 8; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
      chk("wrap_count", int'(count), 8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_empty", int'(empty), 1);

    // Flush at count 10 with requests ignored and flags untouched
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("preflush_count", int'(count), 10);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_unf_kept", int'(unf), 1);
    chk("flush_ovf_kept", int'(ovf), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("errclr2_unf", int'(unf), 0);
    chk("errclr2_ovf", int'(ovf), 0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("postflush_head", int'(rdata), 8'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Registered read mode
    step0(1'b1, 8'hA5, 1'b0);
    step0(1'b1, 8'h5A, 1'b0);
    chk("reg_count", int'(count0), 2);
    step0(1'b0, 8'h00, 1'b1);
    chk("reg_first", int'(rdata0), 8'hA5);
    for (int i = 0; i < 3; i++) begin
      step0(1'b0, 8'h00, 1'b0);
      chk("reg_hold", int'(rdata0), 8'hA5);
    end
    step0(1'b0, 8'h00, 1'b1);
    chk("reg_second", int'(rdata0), 8'h5A);
    step0(1'b0, 8'h00, 1'b1);
    chk("reg_hold_empty", int'(rdata0), 8'h5A);
    chk("reg_unf", int'(unf0), 1);

    // Reset mid-stream with a write pending
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step0(1'b1, 8'h11, 1'b0);
    winc = 1'b1; wdata = 8'hDD; winc0 = 1'b1; wdata0 = 8'hDD; rst_n = 1'b0;
    @(posedge clk); #1;
    winc = 1'b0; winc0 = 1'b0;
    mq.delete(); mq0.delete(); mcount = 0;
    chk_reset_state("midrst");
    chk("midrst_unf0", int'(unf0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Single-clock, parametrised FIFO for the UART transmit path, replacing the dual-clock pointer-synchroniser FIFO wherever producer and consumer share one clock. Adds configurable data width, power-of-two depth, an occupancy count, programmable almost-full and almost-empty thresholds, a show-ahead/registered read mode, a synchronous flush, and sticky overflow/underflow error flags. Sits between the CPU-side UART register interface (writer) and the UART transmitter shift engine (reader).

## Interface
- DATA_WIDTH, 8, bits per entry (≥1)
- FIFO_DEPTH, 16, number of entries; power of two, ≥2
- PTR_WIDTH, $clog2(FIFO_DEPTH)+1, width of internal pointers and of count output (derived; do not override)
- AF_THRESH, FIFO_DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..FIFO_DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..FIFO_DEPTH-1)
- FWFT, 1, read mode: 1 = show-ahead, 0 = registered read
- i_riscv_fifo_clk  input  1  single clock, all logic on rising edge
- i_riscv_fifo_rst_n  input  1  reset, synchronous, active-low
- i_riscv_fifo_flush  input  1  synchronous clear of contents
- i_riscv_fifo_err_clr  input  1  clears sticky error flags
- i_riscv_fifo_winc  input  1  write request
- i_riscv_fifo_wdata  input  DATA_WIDTH  write data
- i_riscv_fifo_rinc  input  1  read request
- o_riscv_fifo_rdata  output  DATA_WIDTH  read data
- o_riscv_fifo_full  output  1  count == FIFO_DEPTH
- o_riscv_fifo_empty  output  1  count == 0
- o_riscv_fifo_almost_full  output  1  count ≥ AF_THRESH
- o_riscv_fifo_almost_empty  output  1  count ≤ AE_THRESH
- o_riscv_fifo_count  output  PTR_WIDTH  current occupancy, 0..FIFO_DEPTH
- o_riscv_fifo_overflow  output  1  sticky: write rejected because full
- o_riscv_fifo_underflow  output  1  sticky: read rejected because empty

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH array, not reset. Write/read pointers PTR_WIDTH bits, low PTR_WIDTH-1 bits address, wrap naturally modulo 2·FIFO_DEPTH.
- Priority per cycle: reset > flush > read/write.
- Read accepted (rd_ok) = rinc & !empty. Write accepted (wr_ok) = winc & (!full | rd_ok).
- Full with winc & rinc: both accepted, count unchanged, no overflow.
- Empty with winc & rinc: write accepted, read rejected, underflow set, count → 1.
- winc & full & !rinc: write dropped, overflow set. rinc & empty: read dropped, underflow set.
- count next = count + wr_ok − rd_ok. All status outputs are decoded from the registered count only (glitch-free, no combinational path from winc/rinc).
- FWFT=1: rdata = mem[raddr] combinationally; valid whenever !empty; rinc pops the displayed word. Value when empty is don't-care.
- FWFT=0: rdata is a register loaded with mem[raddr] on rd_ok; holds otherwise, including across empty and flush.
- Flush: pointers and count → 0; winc/rinc that cycle ignored, no error flags set; memory and error flags untouched.
- err_clr: both sticky flags → 0; an error event in the same cycle wins (flag stays 1).
- Reset values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, rdata 0 (FWFT=0 register).

## Timing
- Write at edge N: data stored, count/empty/almost flags update, visible after edge N.
- FWFT=1 latency write→rdata: first word visible in cycle after write edge (empty deasserts same cycle).
- FWFT=0: rinc sampled at edge N; rdata valid after edge N, held until next rd_ok.
- Error flags set at the edge where the rejected request is sampled.
- Reset mid-operation: all state returns to reset values at the next rising edge with rst_n low; in-flight requests that cycle discarded.

## Test plan
- Reset then fill: DATA_WIDTH=8, DEPTH=16; write 0x00..0x0F → count 16, full=1, almost_full from count 14, empty=0; 17th write → overflow=1, count stays 16.
- Drain, FWFT=1: rdata shows 0x00 before first rinc; 16 reads return 0x00..0x0F in order; then rinc → underflow=1, empty=1, count 0.
- FWFT=0: write 0xA5, 0x5A; rinc at edge N → rdata 0xA5 after N; no rinc for 3 cycles → rdata holds 0xA5.
- Simultaneous ops: at full, winc+rinc → count stays 16, no overflow; at empty, winc(0x3C)+rinc → count 1, underflow=1, next read returns 0x3C.
- Wrap-around: 40 interleaved write/read pairs with random data at count 8 → data order preserved across pointer wrap, count constant 8.
- Flush/err_clr: count 10, flush with winc+rinc → count 0, empty 1, flags unchanged; err_clr → overflow=underflow=0; rst_n low mid-stream → all outputs at reset values next cycle.
